// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache write-buffer drain path.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2,
    REQ  = 2'd3
  } drain_state_t;

  localparam int DRAIN_ADDR_W  = 8;
  localparam int DRAIN_DATA_W  = 8;
  localparam int DRAIN_CNT_W   = 8;
  localparam int DRAIN_TIMEOUT = 15;
  localparam int TIMEOUT_CNT_W = 4;

  // Entry layout: data sits in the low field, the address directly above it.
  localparam int ENTRY_DATA_LSB = 0;

endpackage

// File: rtl/fifo_drain_ctrl.sv
// Write-buffer drain controller: pops FIFO entries and replays them as memory writes.
// Optional ack-wait timeout with retry is built when DRAIN_TIMEOUT_EN is defined.
module fifo_drain_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = DRAIN_ADDR_W,
  parameter int DATA_W  = DRAIN_DATA_W,
  parameter int ENTRY_W = ADDR_W + DATA_W,
  parameter int CNT_W   = DRAIN_CNT_W,
  parameter int TIMEOUT = DRAIN_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fifo_empty,
  input  logic [ENTRY_W-1:0] fifo_data,
  output logic               fifo_pop,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic               flush,
  output logic               flush_done,
  output logic               busy,
  output logic [CNT_W-1:0]   drained_cnt
`ifdef DRAIN_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  localparam int ENTRY_ADDR_LSB = ENTRY_DATA_LSB + DATA_W;

  if (ENTRY_W != ADDR_W + DATA_W) begin : g_bad_entry_w
    $error("fifo_drain_ctrl: ENTRY_W must equal ADDR_W + DATA_W");
  end
  if (TIMEOUT < 1 || TIMEOUT > (1 << TIMEOUT_CNT_W) - 1) begin : g_bad_timeout
    $error("fifo_drain_ctrl: TIMEOUT does not fit the ack-wait counter");
  end

  drain_state_t state, state_next;
  logic         req_active;
  logic         ack_taken;

  assign ack_taken = req_active && mem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The pop strobe is gated by !fifo_empty so an empty FIFO is never popped.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    mem_req    = req_active;
    busy       = (state != IDLE);
    flush_done = flush && fifo_empty && (state == IDLE);
    case (state)
      IDLE:    if (!fifo_empty) state_next = POP;
      POP: begin
        fifo_pop   = !fifo_empty;
        state_next = LOAD;
      end
      LOAD:    state_next = REQ;
      REQ:     if (ack_taken) state_next = fifo_empty ? IDLE : POP;
      default: state_next = IDLE;
    endcase
  end

  // fifo_data is valid in LOAD because the FIFO read is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      drained_cnt <= '0;
    end else begin
      if (state == LOAD) begin
        mem_addr  <= fifo_data[ENTRY_ADDR_LSB +: ADDR_W];
        mem_wdata <= fifo_data[ENTRY_DATA_LSB +: DATA_W];
      end
      if (ack_taken) begin
        drained_cnt <= drained_cnt + CNT_W'(1);
      end
    end
  end

`ifdef DRAIN_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] WAIT_LAST = TIMEOUT_CNT_W'(TIMEOUT - 1);

  logic [TIMEOUT_CNT_W-1:0] wait_cnt;
  logic                     retry_gap;

  assign req_active = (state == REQ) && !retry_gap;

  // A request left unacknowledged for TIMEOUT cycles is withdrawn for one
  // cycle and then re-issued with the same address and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      retry_gap   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      retry_gap <= 1'b0;
      if (req_active && !mem_ack) begin
        if (wait_cnt == WAIT_LAST) begin
          wait_cnt    <= '0;
          retry_gap   <= 1'b1;
          timeout_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + TIMEOUT_CNT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end
`else
  assign req_active = (state == REQ);
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl with a behavioural write-buffer FIFO and memory responder.
// The retry scenario is exercised only when DRAIN_TIMEOUT_EN is defined.
module tb_fifo_drain_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data = '0;
  logic        fifo_pop;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic        flush;
  logic        flush_done;
  logic        busy;
  logic [7:0]  drained_cnt;
`ifdef DRAIN_TIMEOUT_EN
  logic        timeout_err;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pop_count   = 0;
  int req_cycles  = 0;
  int ack_delay   = 1;
  bit ack_on      = 1'b1;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];

  fifo_drain_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_pop    (fifo_pop),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .flush       (flush),
    .flush_done  (flush_done),
    .busy        (busy),
    .drained_cnt (drained_cnt)
`ifdef DRAIN_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Registered-read FIFO model; a push becomes visible on fifo_empty after the next edge.
  always @(posedge clk) begin
    if (fifo_pop && fifo_q.size() != 0) begin
      fifo_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    fifo_q.push_back({addr, data});
    exp_q.push_back({addr, data});
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || !fifo_empty || fifo_q.size() != 0) && n < budget);
    if (n >= budget) checkOutput(name, 32'(busy), 32'd0);
  endtask

  task automatic waitReq(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < budget);
    if (!mem_req) checkOutput(name, 32'(mem_req), 32'd1);
  endtask

  // Memory responder and monitor: each accepted write is checked against the scoreboard.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_pop) pop_count++;
      if (mem_ack) begin
        mem_ack    = 1'b0;
        req_cycles = 0;
      end else if (mem_req && !reset) begin
        if (ack_on && req_cycles >= ack_delay) begin
          if (exp_q.size() == 0) begin
            checkOutput("write_unexpected", {16'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
          end else begin
            checkOutput("write_order", {16'h0, mem_addr, mem_wdata}, {16'h0, exp_q.pop_front()});
          end
          mem_ack = 1'b1;
        end
        req_cycles++;
      end else begin
        req_cycles = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pops_before;
    int n;
    reset = 1'b1;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_req", 32'(mem_req), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_fifo_pop", 32'(fifo_pop), 0);
    checkOutput("rst_flush_done", 32'(flush_done), 0);
    checkOutput("rst_drained_cnt", 32'(drained_cnt), 0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 0);
`ifdef DRAIN_TIMEOUT_EN
    checkOutput("rst_timeout_err", 32'(timeout_err), 0);
`endif
    reset = 1'b0;

    $display("[TB] four-entry ordered drain");
    pops_before = pop_count;
    applyStimulus(8'h10, 8'hA2);
    applyStimulus(8'h11, 8'hA8);
    applyStimulus(8'h12, 8'h1C);
    applyStimulus(8'h13, 8'h8B);
    waitIdle("drain4_idle_timeout", 100);
    checkOutput("drain4_pops", 32'(pop_count - pops_before), 4);
    checkOutput("drain4_cnt", 32'(drained_cnt), 4);
    checkOutput("drain4_busy", 32'(busy), 0);
    checkOutput("drain4_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] empty FIFO stays quiet");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("idle_quiet", {29'h0, fifo_pop, mem_req, busy}, 0);
    end

    $display("[TB] flush with three entries queued");
    flush = 1'b1;
    applyStimulus(8'h30, 8'h01);
    applyStimulus(8'h31, 8'h02);
    applyStimulus(8'h32, 8'h03);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drained_cnt != 8'd7) checkOutput("flush_done_early", 32'(flush_done), 0);
    end while (drained_cnt != 8'd7 && n < 100);
    checkOutput("flush_cnt", 32'(drained_cnt), 7);
    checkOutput("flush_done", 32'(flush_done), 1);
    checkOutput("flush_busy", 32'(busy), 0);
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_done_release", 32'(flush_done), 0);

    $display("[TB] reset during an outstanding request");
    ack_on = 1'b0;
    fifo_q.push_back({8'h20, 8'h33});
    waitReq("rstreq_no_req", 20);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstreq_mem_req", 32'(mem_req), 0);
    checkOutput("rstreq_busy", 32'(busy), 0);
    checkOutput("rstreq_cnt", 32'(drained_cnt), 0);
    reset = 1'b0;
    ack_on = 1'b1;
    pops_before = pop_count;
    repeat (10) @(negedge clk);
    checkOutput("rstreq_no_pop", 32'(pop_count - pops_before), 0);
    checkOutput("rstreq_idle", {30'h0, mem_req, busy}, 0);
    applyStimulus(8'h21, 8'h44);
    waitIdle("rstreq_idle_timeout", 50);
    checkOutput("rstreq_after_cnt", 32'(drained_cnt), 1);

    $display("[TB] 256-entry drain wraps the counter");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ack_delay = 0;
    pops_before = pop_count;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      applyStimulus(a, a ^ 8'h5A);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (drained_cnt != 8'hFF && n < 2500);
    checkOutput("wrap_reach_ff", 32'(drained_cnt), 32'hFF);
    waitIdle("wrap_idle_timeout", 50);
    checkOutput("wrap_cnt_zero", 32'(drained_cnt), 0);
    checkOutput("wrap_pops", 32'(pop_count - pops_before), 256);
    checkOutput("wrap_sb_empty", 32'(exp_q.size()), 0);

`ifdef DRAIN_TIMEOUT_EN
    $display("[TB] ack timeout and retry");
    ack_on = 1'b0;
    applyStimulus(8'h5C, 8'hE7);
    waitReq("to_no_req", 20);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checkOutput("to_req_held", {30'h0, mem_req, timeout_err}, 32'h2);
    end
    @(negedge clk);
    checkOutput("to_req_gap", 32'(mem_req), 0);
    checkOutput("to_err_set", 32'(timeout_err), 1);
    checkOutput("to_cnt_hold", 32'(drained_cnt), 0);
    @(negedge clk);
    checkOutput("to_req_retry", 32'(mem_req), 1);
    checkOutput("to_retry_entry", {16'h0, mem_addr, mem_wdata}, 32'h5CE7);
    ack_on = 1'b1;
    waitIdle("to_idle_timeout", 50);
    checkOutput("to_cnt_after", 32'(drained_cnt), 1);
    checkOutput("to_err_sticky", 32'(timeout_err), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
